portb_irq_detect: RTL and testbench

- Upstream interrupt-source front end for the CPU core: watches the PORTB pins and turns pin activity into interrupt requests.
- Covers the RB0/INT external interrupt and the PORTB interrupt-on-change (IOC) events.
- Synchronises the asynchronous pins, detects configurable edges and keeps the IOCBP/IOCBN/IOCBF register state.
- Drives stretched request pulses onto the core's INT_in and IOC_in inputs, so the multi-cycle core sees each event at its state-0 interrupt check.

---
 rtl/portb_irq_detect_pkg.sv | 18 +
 rtl/irq_pulse_stretch.sv | 46 ++++
 rtl/portb_irq_detect.sv | 131 +++++++++++++
 tb/tb_portb_irq_detect.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/portb_irq_detect_pkg.sv
// Shared constants for the PORTB interrupt front end: register map, CTRL bit
// positions and the CTRL reset value.
package portb_irq_detect_pkg;

  // Register select values on reg_addr.
  localparam logic [1:0] ADDR_IOCBP = 2'd0;
  localparam logic [1:0] ADDR_IOCBN = 2'd1;
  localparam logic [1:0] ADDR_IOCBF = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  // CTRL bit positions.
  localparam int unsigned CTRL_INTEDG  = 0;
  localparam int unsigned CTRL_INT_DIS = 1;

  // INTEDG=1 (rising edge), INT_DIS=0.
  localparam logic [7:0] CTRL_RST = 8'h01;

endpackage

// File: rtl/irq_pulse_stretch.sv
// Request stretcher: each event (re)loads a down-counter with PULSE_LEN and the
// request stays high while the counter is non-zero, so the multi-cycle core is
// guaranteed to see it at its next interrupt check.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   evt_i : single-cycle event
//   req_o : registered stretched request
module irq_pulse_stretch #(
  parameter int unsigned PULSE_LEN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic evt_i,
  output logic req_o
);

  localparam int unsigned CntW = $clog2(PULSE_LEN + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;

  always_comb begin
    cnt_d = cnt_q;
    if (evt_i) begin
      // Retrigger reloads rather than accumulates.
      cnt_d = CntW'(PULSE_LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
    // Registered view of (counter != 0): high the cycle after the event.
    req_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/portb_irq_detect.sv
// PORTB interrupt-source front end. Synchronises the PORTB pins, detects edges,
// maintains IOCBP/IOCBN/IOCBF/CTRL and drives stretched INT and IOC requests.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   rb_pin      : raw asynchronous PORTB levels, bit 0 is INT
//   reg_we      : register write strobe
//   reg_addr    : 0=IOCBP 1=IOCBN 2=IOCBF 3=CTRL
//   reg_wdata   : write data
//   reg_rdata   : combinational read of the selected register
//   int_req     : stretched INT request
//   ioc_req     : stretched IOC request
//   ioc_pending : high while any IOCBF flag is set
module portb_irq_detect
  import portb_irq_detect_pkg::*;
#(
  parameter int unsigned PORT_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] rb_pin,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  output logic              int_req,
  output logic              ioc_req,
  output logic              ioc_pending
);

  logic [PORT_W-1:0] sync_q [SYNC_STAGES];
  logic [PORT_W-1:0] sync_d [SYNC_STAGES];
  logic [PORT_W-1:0] prev_q;
  logic [PORT_W-1:0] iocbp_q, iocbp_d;
  logic [PORT_W-1:0] iocbn_q, iocbn_d;
  logic [PORT_W-1:0] iocbf_q, iocbf_d;
  logic [1:0]        ctrl_q, ctrl_d;

  logic [PORT_W-1:0] s, rise, fall, ioc_set;
  logic              int_event, ioc_event;

  always_comb begin
    sync_d[0] = rb_pin;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // Edge enables come from the registered IOCBP/IOCBN, so a write only
  // affects edges in the following cycle.
  assign ioc_set   = (rise & iocbp_q) | (fall & iocbn_q);
  assign ioc_event = |ioc_set;
  assign int_event = ~ctrl_q[CTRL_INT_DIS] &
                     (ctrl_q[CTRL_INTEDG] ? rise[0] : fall[0]);

  always_comb begin
    iocbp_d = iocbp_q;
    iocbn_d = iocbn_q;
    ctrl_d  = ctrl_q;
    // Software may only clear flags; a hardware set in the same cycle wins.
    iocbf_d = iocbf_q | ioc_set;
    if (reg_we) begin
      unique case (reg_addr)
        ADDR_IOCBP: iocbp_d = reg_wdata[PORT_W-1:0];
        ADDR_IOCBN: iocbn_d = reg_wdata[PORT_W-1:0];
        ADDR_IOCBF: iocbf_d = (iocbf_q & reg_wdata[PORT_W-1:0]) | ioc_set;
        ADDR_CTRL:  ctrl_d  = reg_wdata[1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      prev_q  <= '0;
      iocbp_q <= '0;
      iocbn_q <= '0;
      iocbf_q <= '0;
      ctrl_q  <= CTRL_RST[1:0];
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q  <= s;
      iocbp_q <= iocbp_d;
      iocbn_q <= iocbn_d;
      iocbf_q <= iocbf_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      ADDR_IOCBP: reg_rdata = 8'(iocbp_q);
      ADDR_IOCBN: reg_rdata = 8'(iocbn_q);
      ADDR_IOCBF: reg_rdata = 8'(iocbf_q);
      ADDR_CTRL:  reg_rdata = {6'b0, ctrl_q};
      default:    reg_rdata = '0;
    endcase
  end

  assign ioc_pending = |iocbf_q;

  irq_pulse_stretch #(
    .PULSE_LEN(PULSE_LEN)
  ) u_int_stretch (
    .clk  (clk),
    .rst  (rst),
    .evt_i(int_event),
    .req_o(int_req)
  );

  irq_pulse_stretch #(
    .PULSE_LEN(PULSE_LEN)
  ) u_ioc_stretch (
    .clk  (clk),
    .rst  (rst),
    .evt_i(ioc_event),
    .req_o(ioc_req)
  );

endmodule

// File: tb/tb_portb_irq_detect.sv
// Self-checking bench for portb_irq_detect: hand-written vector table, directed
// corner sequences and random stimulus against a cycle-level reference model.
module tb_portb_irq_detect;

  localparam int SS = 2;
  localparam int PL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rb_pin;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       int_req, ioc_req, ioc_pending;

  int checks = 0;
  int errors = 0;

  portb_irq_detect #(
    .PORT_W     (8),
    .SYNC_STAGES(SS),
    .PULSE_LEN  (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rb_pin     (rb_pin),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .int_req    (int_req),
    .ioc_req    (ioc_req),
    .ioc_pending(ioc_pending)
  );

  always #5 clk = ~clk;

  // Reference model: pin samples seen at each clock edge (newest first),
  // register contents, and the cycle of the latest event per request.
  logic [7:0] m_hist[$];
  logic [7:0] m_p, m_n, m_f;
  logic [1:0] m_ctrl;
  int         m_cyc, m_last_int, m_last_ioc;

  task automatic model_reset();
    m_hist = {};
    repeat (SS + 1) m_hist.push_back(8'h00);
    m_p = 0; m_n = 0; m_f = 0; m_ctrl = 2'b01;
    m_cyc = 0; m_last_int = -1000; m_last_ioc = -1000;
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_p;
      2'd1:    return m_n;
      2'd2:    return m_f;
      default: return {6'b0, m_ctrl};
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [7:0] cur, old, rise, fall, set;
    logic       int_ev;
    cur    = m_hist[SS-1];
    old    = m_hist[SS];
    rise   = cur & ~old;
    fall   = ~cur & old;
    set    = (rise & m_p) | (fall & m_n);
    int_ev = !m_ctrl[1] && (m_ctrl[0] ? rise[0] : fall[0]);
    if (reg_we && reg_addr == 2'd2) m_f = (m_f & reg_wdata) | set;
    else                            m_f = m_f | set;
    if (reg_we && reg_addr == 2'd0) m_p = reg_wdata;
    if (reg_we && reg_addr == 2'd1) m_n = reg_wdata;
    if (reg_we && reg_addr == 2'd3) m_ctrl = reg_wdata[1:0];
    m_hist.push_front(rb_pin);
    void'(m_hist.pop_back());
    if (int_ev) m_last_int = m_cyc;
    if (set != 0) m_last_ioc = m_cyc;
    m_cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic ei, eo;
    ei = (m_cyc - m_last_int) >= 1 && (m_cyc - m_last_int) <= PL;
    eo = (m_cyc - m_last_ioc) >= 1 && (m_cyc - m_last_ioc) <= PL;
    chk("model_int_req", {7'd0, int_req}, {7'd0, ei});
    chk("model_ioc_req", {7'd0, ioc_req}, {7'd0, eo});
    chk("model_ioc_pending", {7'd0, ioc_pending}, {7'd0, m_f != 0});
    chk("model_rdata", reg_rdata, m_read(reg_addr));
  endtask

  // One clock: model sees the same inputs as the DUT, then outputs are
  // checked 1 time unit after the edge and the write strobe is dropped.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    reg_we = 1'b0;
    chk_model();
  endtask

  task automatic run(input int n, output int n_int, output int n_ioc);
    n_int = 0;
    n_ioc = 0;
    for (int i = 0; i < n; i++) begin
      step();
      n_int += int'(int_req);
      n_ioc += int'(ioc_req);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    step();
  endtask

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] pin;
    logic       e_int;
    logic       e_ioc;
    logic       e_pend;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int a, b, c, d;
    // IOC on RB5: enable, raise pin, flag at 3rd edge, 6-cycle pulse, clear.
    vecs[0]  = '{1'b1, 2'd0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20};
    vecs[1]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[4]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[5]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[6]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[7]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[8]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[9]  = '{1'b0, 2'd2, 8'h00, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20};
    vecs[10] = '{1'b1, 2'd2, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00};

    rst = 1'b0; rb_pin = 8'h00; reg_we = 1'b0; reg_addr = 2'd3; reg_wdata = 8'h00;
    model_reset();
    #12;
    chk("rst_int_req", {7'd0, int_req}, 8'h00);
    chk("rst_ioc_req", {7'd0, ioc_req}, 8'h00);
    chk("rst_ioc_pending", {7'd0, ioc_pending}, 8'h00);
    chk("rst_ctrl", reg_rdata, 8'h01);
    @(posedge clk); #1;
    rst = 1'b1;
    run(4, a, b);
    chk("idle_int", 8'(a), 8'd0);
    chk("idle_ioc", 8'(b), 8'd0);

    for (int i = 0; i < 11; i++) begin
      reg_we = vecs[i].we; reg_addr = vecs[i].addr; reg_wdata = vecs[i].wdata;
      rb_pin = vecs[i].pin;
      step();
      chk($sformatf("tbl%0d_int", i), {7'd0, int_req}, {7'd0, vecs[i].e_int});
      chk($sformatf("tbl%0d_ioc", i), {7'd0, ioc_req}, {7'd0, vecs[i].e_ioc});
      chk($sformatf("tbl%0d_pend", i), {7'd0, ioc_pending}, {7'd0, vecs[i].e_pend});
      chk($sformatf("tbl%0d_rdata", i), reg_rdata, vecs[i].e_rdata);
    end

    // INT edge select on RB0.
    rb_pin = 8'h21; run(12, a, b);
    chk("int_rise_len", 8'(a), 8'd6);
    chk("int_rise_noioc", 8'(b), 8'd0);
    rb_pin = 8'h20; run(8, a, b);
    chk("int_fall_ignored", 8'(a), 8'd0);
    wr(2'd3, 8'h00);
    rb_pin = 8'h21; run(8, a, b);
    chk("int_rise_ignored", 8'(a), 8'd0);
    rb_pin = 8'h20; run(12, a, b);
    chk("int_fall_len", 8'(a), 8'd6);

    // Hardware set beats a same-cycle software clear.
    wr(2'd1, 8'h01);
    rb_pin = 8'h21; run(6, a, b);
    rb_pin = 8'h20; reg_addr = 2'd2; run(8, a, b);
    chk("preset_flag", reg_rdata, 8'h01);
    rb_pin = 8'h21; run(6, a, b);
    rb_pin = 8'h20; step(); step();
    wr(2'd2, 8'h00);
    chk("set_wins", reg_rdata, 8'h01);
    wr(2'd2, 8'h00);
    chk("clear_flag", reg_rdata, 8'h00);
    chk("clear_pending", {7'd0, ioc_pending}, 8'h00);

    // Retrigger: RB5 then RB6 rising three cycles apart.
    rb_pin = 8'h00; run(8, a, b);
    wr(2'd0, 8'h60);
    rb_pin = 8'h20; run(3, a, b);
    rb_pin = 8'h60; run(14, c, d);
    chk("retrigger_len", 8'(b + d), 8'd9);
    wr(2'd2, 8'h00);

    // Reset while int_req is high.
    wr(2'd3, 8'h01);
    rb_pin = 8'h61; run(4, a, b);
    chk("pre_reset_int", {7'd0, int_req}, 8'h01);
    rst = 1'b0; #1;
    chk("async_rst_int", {7'd0, int_req}, 8'h00);
    chk("async_rst_ioc", {7'd0, ioc_req}, 8'h00);
    rb_pin = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1; model_reset();
    run(10, a, b);
    chk("no_residual_int", 8'(a), 8'd0);

    // Pin already high at release is seen as a rising edge.
    rst = 1'b0; rb_pin = 8'h01;
    @(posedge clk); #1;
    rst = 1'b1; model_reset();
    run(10, a, b);
    chk("held_high_int", 8'(a), 8'd6);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rb_pin = rb_pin ^ 8'($urandom_range(255));
      reg_addr = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) begin
        reg_we = 1'b1; reg_wdata = 8'($urandom_range(255));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
